accu_delta_decoder: RTL and testbench

//   Inverse of the accumulator: consumes the running-sum stream (accu output) and recovers the
//   per-cycle increments, delta = sum[n] - sum[n-1] mod 2^WIDTH.

---
 rtl/accu_delta_decoder.sv | 100 ++++++++++
 tb/tb_accu_delta_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/accu_delta_decoder.sv
// Recovers per-cycle increments from an accumulator running-sum stream and
// buffers them in a small valid/ready FIFO.
module accu_delta_decoder #(
    parameter int              WIDTH = 8,
    parameter int              DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         sum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         delta,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SEED = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_prev;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [WIDTH-1:0]  w_diff;

    // Flow control is decoded from the registered level only, so no
    // combinational path exists between the input and output handshakes.
    assign in_ready  = (r_level != LW'(DEPTH));
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign delta     = r_mem[r_rd_ptr];

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = w_accept & ~sync & (r_state == ST_RUN);
    assign w_diff    = sum_in - r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_prev   <= INIT;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            // NOTE: the buffer is small and delta must read 0 out of reset,
            // so every entry is cleared here rather than left uninitialised.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // A sample accepted together with sync, or while waiting in SEED,
            // only becomes the new reference; it produces no delta.
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_prev <= sum_in;
                    end else if (sync) begin
                        r_state <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    if (w_accept) begin
                        r_prev  <= sum_in;
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            if (w_push) begin
                r_mem[r_wr_ptr] <= w_diff;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_accu_delta_decoder.sv
// Directed self-checking bench for accu_delta_decoder (WIDTH=8, DEPTH=4, INIT=0).
module tb_accu_delta_decoder;

    logic       clk;
    logic       rst;
    logic       sync;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sum_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] delta;
    logic [2:0] level;

    int n_checks = 0;
    int n_errors = 0;

    accu_delta_decoder #(
        .WIDTH (8),
        .DEPTH (4),
        .INIT  (8'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .delta     (delta),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        sync      = 1'b0;
        in_valid  = 1'b0;
        sum_in    = 8'd0;
        out_ready = 1'b0;

        // Reset state, no clock edge needed
        #3;
        check("rst_level",     level,     0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_delta",     delta,     0);
        #9 rst = 1'b0;
        cycle();

        // T1: sum 1..5 back to back, each delta 1 visible right after its accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            sum_in = 8'(v);
            cycle();
            check("t1_valid", out_valid, 1);
            check("t1_delta", delta,     1);
            check("t1_level", level,     1);
        end
        in_valid = 1'b0;
        cycle();
        check("t1_drain", level, 0);

        // T4: sync alone, then 100 (seed) and 103 -> delta 3
        sync = 1'b1;
        cycle();
        sync     = 1'b0;
        in_valid = 1'b1;
        sum_in   = 8'd100;
        cycle();
        check("t4_seed_valid", out_valid, 0);
        check("t4_seed_level", level,     0);
        sum_in = 8'd103;
        cycle();
        check("t4_valid", out_valid, 1);
        check("t4_delta", delta,     3);
        in_valid = 1'b0;
        cycle();
        check("t4_drain", level, 0);

        // T4b: sync with accepted 200, then 205 -> single delta 5
        sync     = 1'b1;
        in_valid = 1'b1;
        sum_in   = 8'd200;
        cycle();
        check("t4b_seed_level", level, 0);
        sync   = 1'b0;
        sum_in = 8'd205;
        cycle();
        check("t4b_delta", delta, 5);
        check("t4b_level", level, 1);
        in_valid = 1'b0;
        cycle();
        check("t4b_drain", level, 0);

        // T2: fresh reference, 250 then 4 -> 250, 10 (modular)
        do_reset();
        in_valid = 1'b1;
        sum_in   = 8'd250;
        cycle();
        check("t2_valid0", out_valid, 1);
        check("t2_delta0", delta,     250);
        sum_in = 8'd4;
        cycle();
        check("t2_delta1", delta, 10);
        in_valid = 1'b0;
        cycle();
        check("t2_drain", level, 0);

        // Re-seed with 0 so T3 starts from reference 0
        sync     = 1'b1;
        in_valid = 1'b1;
        sum_in   = 8'd0;
        cycle();
        sync = 1'b0;
        check("seed0_level", level, 0);

        // T3: backpressure, 10..40 fill the FIFO, 50 held off
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sum_in = 8'(10 * k);
            cycle();
            check("t3_fill_level", level, 32'(k));
        end
        check("t3_full_ready", in_ready, 0);
        sum_in = 8'd50;
        cycle();
        check("t3_hold_level", level,    4);
        check("t3_hold_ready", in_ready, 0);
        check("t3_hold_delta", delta,    10);
        cycle();
        check("t3_hold_level2", level, 4);
        check("t3_hold_delta2", delta, 10);
        out_ready = 1'b1;
        cycle();
        check("t3_rel_level", level, 3);
        check("t3_rel_delta", delta, 10);
        cycle();
        check("t3_push50_level", level, 3);
        check("t3_push50_delta", delta, 10);
        in_valid = 1'b0;
        for (int k = 2; k >= 1; k--) begin
            cycle();
            check("t3_drain_level", level, 32'(k));
            check("t3_drain_delta", delta, 10);
        end
        cycle();
        check("t3_empty", out_valid, 0);

        // T5: level 2, then push and pop on the same edge
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_in    = 8'd51;
        cycle();
        sum_in = 8'd53;
        cycle();
        check("t5_level2", level, 2);
        check("t5_head",   delta, 1);
        out_ready = 1'b1;
        sum_in    = 8'd56;
        cycle();
        check("t5_same_level", level, 2);
        check("t5_same_delta", delta, 2);
        in_valid = 1'b0;
        cycle();
        check("t5_tail_level", level, 1);
        check("t5_tail_delta", delta, 3);
        cycle();
        check("t5_drain", level, 0);

        // T6: async reset between edges while data is buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_in    = 8'd60;
        cycle();
        sum_in = 8'd61;
        cycle();
        check("t6_pre_level", level, 2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_level", level,     0);
        check("t6_rst_ready", in_ready,  1);
        check("t6_rst_delta", delta,     0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        cycle();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sum_in    = 8'd7;
        cycle();
        check("t6_post_valid", out_valid, 1);
        check("t6_post_delta", delta,     7);
        check("t6_post_level", level,     1);
        in_valid = 1'b0;
        cycle();
        check("t6_post_drain", level, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
